disp_scan_ctrl: RTL

- Time-multiplexed scan controller that shares one disp_deco hex-to-7-segment decoder across N_DIGITS common-anode digits.
- Holds a frame of hex nibbles and presents one nibble per slot on the decoder's x,y,z,w inputs (nibble[3]=x … nibble[0]=w).
- Drives the matching active-low digit enable, inserting a guard gap between slots.
- Sits between the value source (counter or register file) and the disp_deco instance that feeds the board display.

---
 rtl/disp_pkg.sv | 17 +
 rtl/disp_slot_timer.sv | 37 +++
 rtl/disp_scan_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and default constants for the multiplexed display scan controller.
package disp_pkg;

    typedef enum logic [1:0] {OFF, SHOW, GUARD} scan_state_t;

    typedef logic [3:0] hex_t;

    localparam int DISP_N_DIGITS    = 4;
    localparam int DISP_REFRESH_DIV = 50000;
    localparam int DISP_GUARD_CYC   = 16;

    // Slot counter width: enough to hold the longer of the two slot lengths minus one.
    function automatic int cnt_width(input int a, input int b);
        return (a > b) ? $clog2(a) : $clog2(b);
    endfunction

endpackage

// File: rtl/disp_slot_timer.sv
// Loadable down-counter; done is high during the last cycle of a started interval.
module disp_slot_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          clear,
    input  logic [CW:0]   length,
    output logic          done
);

    logic [CW-1:0] cnt_reg;
    logic          run_reg;
    logic [CW:0]   len_m1;

    assign len_m1 = length - (CW+1)'(1);
    assign done   = run_reg && (cnt_reg == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            run_reg <= 1'b0;
        end else if (clear) begin
            cnt_reg <= '0;
            run_reg <= 1'b0;
        end else if (start) begin
            cnt_reg <= len_m1[CW-1:0];
            run_reg <= 1'b1;
        end else if (done) begin
            run_reg <= 1'b0;
        end else if (run_reg) begin
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed hex display scanner with tear-free frame updates.
// Optional leading-zero blanking is enabled by defining DISP_SCAN_LZB_EN.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS    = DISP_N_DIGITS,
    parameter int REFRESH_DIV = DISP_REFRESH_DIV,
    parameter int GUARD_CYC   = DISP_GUARD_CYC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load,
    input  logic [4*N_DIGITS-1:0]         value_in,
    input  logic [N_DIGITS-1:0]           blank_in,
    output logic [3:0]                    nibble,
    output logic [N_DIGITS-1:0]           an,
    output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
    output logic                          frame_done
);

    localparam int CW = cnt_width(REFRESH_DIV, GUARD_CYC);
    localparam int IW = $clog2(N_DIGITS);
    localparam int NW = 4 * N_DIGITS;
    localparam logic [CW:0]   SHOW_LEN  = (CW+1)'(REFRESH_DIV);
    localparam logic [CW:0]   GUARD_LEN = (CW+1)'(GUARD_CYC);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_DIGITS - 1);

    scan_state_t         state_reg, state_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic [N_DIGITS-1:0] an_reg, an_next;
    hex_t                nibble_reg, nibble_next;
    logic                frame_done_reg;
    logic [NW-1:0]       shadow_val_reg, shadow_val_next, pend_val_reg, src_val;
    logic [N_DIGITS-1:0] shadow_blank_reg, shadow_blank_next, pend_blank_reg, src_blank;
    logic [N_DIGITS-1:0] lzb_mask;
    logic                pend_flag_reg;
    logic                start, clear, wrap, slot_done;
    logic [CW:0]         slot_len;

    assign slot_len = (state_next == SHOW) ? SHOW_LEN : GUARD_LEN;

    disp_slot_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .clear  (clear),
        .length (slot_len),
        .done   (slot_done)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        start      = 1'b0;
        clear      = 1'b0;
        wrap       = 1'b0;
        if (!en) begin
            state_next = OFF;
            idx_next   = '0;
            clear      = 1'b1;
        end else begin
            case (state_reg)
                OFF: begin
                    state_next = SHOW;
                    idx_next   = '0;
                    start      = 1'b1;
                end
                SHOW: begin
                    if (slot_done) begin
                        state_next = GUARD;
                        start      = 1'b1;
                    end
                end
                GUARD: begin
                    if (slot_done) begin
                        state_next = SHOW;
                        start      = 1'b1;
                        if (idx_reg == LAST_IDX) begin
                            idx_next = '0;
                            wrap     = 1'b1;
                        end else begin
                            idx_next = idx_reg + IW'(1);
                        end
                    end
                end
                default: state_next = OFF;
            endcase
        end
    end

    // A load on the wrap cycle beats pending; with nothing pending the shadow is re-latched.
    always_comb begin
        src_val   = pend_val_reg;
        src_blank = pend_blank_reg;
        if (load) begin
            src_val   = value_in;
            src_blank = blank_in;
        end else if (!pend_flag_reg) begin
            src_val   = shadow_val_reg;
            src_blank = shadow_blank_reg;
        end
        shadow_val_next   = shadow_val_reg;
        shadow_blank_next = shadow_blank_reg;
        if (wrap) begin
            shadow_val_next   = src_val;
            shadow_blank_next = src_blank | lzb_mask;
        end
    end

`ifdef DISP_SCAN_LZB_EN
    logic [N_DIGITS-1:0] dark_ok;
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lzb
        assign dark_ok[gi] = (src_val[4*gi +: 4] == 4'h0) || src_blank[gi];
        if (gi == 0) begin : g_keep
            assign lzb_mask[gi] = 1'b0;
        end else if (gi == N_DIGITS - 1) begin : g_top
            assign lzb_mask[gi] = (src_val[4*gi +: 4] == 4'h0);
        end else begin : g_mid
            assign lzb_mask[gi] = (src_val[4*gi +: 4] == 4'h0) && (&dark_ok[N_DIGITS-1:gi+1]);
        end
    end
`else
    assign lzb_mask = '0;
`endif

    // Outputs are derived from the next state so they change on the same edge as the state.
    always_comb begin
        an_next     = '1;
        nibble_next = nibble_reg;
        if (state_next == SHOW) begin
            nibble_next       = shadow_val_next[4*idx_next +: 4];
            an_next[idx_next] = shadow_blank_next[idx_next];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= OFF;
            idx_reg          <= '0;
            an_reg           <= '1;
            nibble_reg       <= '0;
            frame_done_reg   <= 1'b0;
            shadow_val_reg   <= '0;
            shadow_blank_reg <= '0;
            pend_val_reg     <= '0;
            pend_blank_reg   <= '0;
            pend_flag_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            idx_reg          <= idx_next;
            an_reg           <= an_next;
            nibble_reg       <= nibble_next;
            frame_done_reg   <= wrap;
            shadow_val_reg   <= shadow_val_next;
            shadow_blank_reg <= shadow_blank_next;
            if (load) begin
                pend_val_reg   <= value_in;
                pend_blank_reg <= blank_in;
                pend_flag_reg  <= !wrap;
            end else if (wrap) begin
                pend_flag_reg  <= 1'b0;
            end
        end
    end

    assign nibble     = nibble_reg;
    assign an         = an_reg;
    assign digit_idx  = idx_reg;
    assign frame_done = frame_done_reg;

endmodule
